// File: rtl/cla_add_scheduler.sv
// Two-requester adder scheduler: arbitrates operand pairs, then adds them one
// 4-bit carry-lookahead nibble per cycle and holds the result until consumed.
module cla_add_scheduler #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         busy
);

  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_id;
  logic          r_last;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_res_valid;
  logic          r_busy;

  logic [1:0]    w_state_nxt;
  logic [W-1:0]  w_a_nxt;
  logic [W-1:0]  w_b_nxt;
  logic          w_id_nxt;
  logic          w_last_nxt;
  logic          w_carry_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [W-1:0]  w_sum_nxt;
  logic          w_cout_nxt;
  logic          w_res_valid_nxt;
  logic          w_busy_nxt;

  logic          w_gnt0;
  logic          w_gnt1;
  logic [3:0]    w_na;
  logic [3:0]    w_nb;
  logic [3:0]    w_g;
  logic [3:0]    w_p;
  logic [4:0]    w_c;
  logic [3:0]    w_nsum;
  logic          w_last_nib;

  // Grant: sole valid requester, or on a tie the one that did not win last.
  assign w_gnt0 = rst_n && (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last);
  assign w_gnt1 = rst_n && (r_state == S_IDLE) && req1_valid && (!req0_valid || !r_last);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Select the operand nibble addressed by the nibble index.
  always_comb begin
    w_na = '0;
    w_nb = '0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (r_idx == IW'(k)) begin
        w_na = r_a[4*k +: 4];
        w_nb = r_b[4*k +: 4];
      end
    end
  end

  // 4-bit carry-lookahead for the current nibble.
  always_comb begin
    w_g    = w_na & w_nb;
    w_p    = w_na ^ w_nb;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_nsum = w_p ^ w_c[3:0];
  end

  assign w_last_nib = (r_idx == IW'(NIBBLES - 1));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_id_nxt        = r_id;
    w_last_nxt      = r_last;
    w_carry_nxt     = r_carry;
    w_idx_nxt       = r_idx;
    w_sum_nxt       = r_sum;
    w_cout_nxt      = r_cout;
    w_res_valid_nxt = r_res_valid;
    w_busy_nxt      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_a_nxt     = w_gnt1 ? req1_a : req0_a;
          w_b_nxt     = w_gnt1 ? req1_b : req0_b;
          w_id_nxt    = w_gnt1;
          w_last_nxt  = w_gnt1;
          w_carry_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < int'(NIBBLES); k++) begin
          if (r_idx == IW'(k)) begin
            w_sum_nxt[4*k +: 4] = w_nsum;
          end
        end
        w_carry_nxt = w_c[4];
        w_idx_nxt   = r_idx + IW'(1);
        if (w_last_nib) begin
          w_cout_nxt      = w_c[4];
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_res_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_id        <= w_id_nxt;
      r_last      <= w_last_nxt;
      r_carry     <= w_carry_nxt;
      r_idx       <= w_idx_nxt;
      r_sum       <= w_sum_nxt;
      r_cout      <= w_cout_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_id    = r_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cla_add_scheduler.sv
// Scoreboard bench for cla_add_scheduler: driver pushes expected results at
// acceptance, an independent monitor pops and checks on each result handshake.
module tb_cla_add_scheduler;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id, busy;
  logic [W-1:0] res_sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           id;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   prev_v = 1'b0;

  cla_add_scheduler #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Wait for an acceptance, check who got it, and queue the expected result.
  task automatic wait_accept(input int exp_id, input logic [W-1:0] es, input logic ec,
                             output int acc);
    bit done = 1'b0;
    acc = -1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        chk("grant_id", {31'd0, req1_ready}, exp_id);
        acc = cyc + 1;
        sb.push_back('{es, ec, exp_id, acc});
        n_push++;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: result latency on rise, payload on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (res_valid && !prev_v && sb.size() > 0) chk("latency", cyc - sb[0].acc, NIB);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("res_sum", {16'd0, res_sum}, {16'd0, mon_e.sum});
          chk("res_cout", {31'd0, res_cout}, {31'd0, mon_e.cout});
          chk("res_id", {31'd0, res_id}, mon_e.id);
          n_pop++;
        end
      end
      prev_v = res_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, rel;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
    req1_valid = 1'b1; req1_a = 16'h9999; req1_b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, res_sum}, 32'd0);
    chk("rst_cout", {31'd0, res_cout}, 32'd0);
    chk("rst_id", {31'd0, res_id}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);

    // Tie straight out of reset: requester 0 first, on the first edge.
    rst_n = 1'b1; rel = cyc;
    wait_accept(0, 16'h3333, 1'b0, acc);
    chk("first_edge_tie", acc, rel + 1);
    req0_valid = 1'b0;
    wait_accept(1, 16'h9998, 1'b1, acc);
    req1_valid = 1'b0;

    wait_idle();
    req0_valid = 1'b1; req0_a = 16'h000A; req0_b = 16'h0005;
    wait_accept(0, 16'h000F, 1'b0, acc);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001;
    wait_accept(1, 16'h0000, 1'b1, acc);
    req1_valid = 1'b0;

    // Backpressure: result must hold while res_ready is low.
    wait_idle();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321;
    wait_accept(0, 16'h5555, 1'b0, acc);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0002;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_sum", {16'd0, res_sum}, 32'h5555);
      chk("hold_cout", {31'd0, res_cout}, 32'd0);
      chk("hold_id", {31'd0, res_id}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
      chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_valid", {31'd0, res_valid}, 32'd0);
    wait_accept(1, 16'h0003, 1'b0, acc);
    req1_valid = 1'b0;

    // Continuous contention: alternate grants, fixed spacing.
    wait_idle();
    req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0202;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(k % 2, (k % 2 != 0) ? 16'h0000 : 16'h0303, (k % 2 != 0), acc);
      if (k > 0) chk("spacing", acc - prev, NIB + 2);
      prev = acc;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset in the second RUN cycle aborts the operation.
    wait_idle();
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
    wait_accept(0, 16'h0003, 1'b0, acc);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_push--;
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {16'd0, res_sum}, 32'd0);
    chk("abort_cout", {31'd0, res_cout}, 32'd0);
    chk("abort_id", {31'd0, res_id}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_stay_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1; rel = cyc;
    req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h0010;
    wait_accept(0, 16'h0100, 1'b0, acc);
    chk("first_edge_after_abort", acc, rel + 1);
    req0_valid = 1'b0;
    wait_idle();
    repeat (8) @(posedge clk);
    #1;
    chk("result_count", n_pop, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_add_scheduler.md
CLA_ADD_SCHEDULER -- requirements
Module: cla_add_scheduler

Interface
REQ-001 The module SHALL have parameter NIBBLES, default 4, giving the number of 4-bit carry-lookahead passes per operation; operand width W = 4*NIBBLES.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port req0_valid  input  1  requester 0 has operands pending.
REQ-006 Port req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 Port req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-008 Port req1_valid, req1_a, req1_b, req1_ready  same directions, widths and meanings as requester 0.
REQ-009 Port res_valid  output  1  result available.
REQ-010 Port res_ready  input  1  consumer accepts result.
REQ-011 Port res_sum  output  W  sum, modulo 2^W.
REQ-012 Port res_cout  output  1  carry out of bit W-1.
REQ-013 Port res_id  output  1  requester index that owns the result.
REQ-014 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The module SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 In IDLE, exactly one ready SHALL be high when any valid is high: the sole valid requester, or, if both are valid, the requester not equal to the last-grant pointer. Both readies SHALL be low when neither valid is high.
REQ-017 Acceptance (valid && ready in IDLE) SHALL latch a, b and id, clear the internal carry and nibble index, set the last-grant pointer to id, and enter RUN.
REQ-018 Readies SHALL be low in RUN and DONE; request inputs SHALL be ignored there.
REQ-019 Each RUN cycle SHALL process nibble i (bits 4i+3:4i) with carry-lookahead equations (g=a&b, p=a^b, c1..c4 from g, p and the carry register), write the 4 sum bits into res_sum[4i+3:4i], load c4 into the carry register, and increment i.
REQ-020 After nibble NIBBLES-1 is written, the FSM SHALL enter DONE; res_valid SHALL rise exactly NIBBLES cycles after the acceptance edge.
REQ-021 In DONE, res_valid SHALL be high and res_sum, res_cout and res_id SHALL hold stable until res_valid && res_ready, after which the FSM SHALL return to IDLE.
REQ-022 res_cout SHALL equal the carry register after the final nibble; {res_cout, res_sum} SHALL equal a+b as an unsigned (W+1)-bit sum.
REQ-023 The earliest new acceptance after a result handshake SHALL be the following edge; minimum spacing between acceptances is NIBBLES+2 cycles.
REQ-024 A requester holding valid high continuously while the other is also valid SHALL be served on alternate acceptances.
REQ-025 res_sum bits not yet written in RUN SHALL hold their previous values; only DONE contents are architecturally defined.

Reset
REQ-026 While rst_n is low, state SHALL be IDLE, and res_valid, res_sum, res_cout, res_id, busy, both readies, the carry register and the nibble index SHALL be 0; the last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation; no result for it SHALL ever be presented.
REQ-028 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-029 req0 a=0x000A b=0x0005 -> res_sum=0x000F, res_cout=0, res_id=0, res_valid 4 cycles after acceptance.
REQ-030 req1 a=0xFFFF b=0x0001 -> res_sum=0x0000, res_cout=1, res_id=1; carry ripples through all four nibbles.
REQ-031 After reset, both valid together, req0 a=0x1111 b=0x2222 and req1 a=0x9999 b=0xFFFF -> first result 0x3333/cout 0/id 0, then 0x9998/cout 1/id 1.
REQ-032 res_ready held low 3 cycles in DONE -> res_valid, res_sum, res_cout and res_id stable, busy=1, readies 0; release -> IDLE next edge.
REQ-033 rst_n pulsed low during the second RUN cycle -> outputs 0 and state IDLE, no res_valid; a following req0 a=0x00F0 b=0x0010 completes with 0x0100/cout 0.
REQ-034 Both valid continuously for 4 operations -> grant order 0,1,0,1; acceptance spacing exactly 6 cycles with res_ready tied high.
